ysyx_22050612_mem_resp: RTL and testbench
=========================================

YSYX_22050612_MEM_RESP -- requirements
Module: ysyx_22050612_mem_resp

Interface
REQ-001 SHALL have parameter BASE, default 64'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of the number of 64-bit words stored (256).
REQ-003 SHALL have parameter LATENCY, default 2, extra wait cycles before a response (legal range 0-15).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request.
REQ-008 SHALL have port req_wen  in  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  64  byte address.
REQ-010 SHALL have port req_wdata  in  64  write data, lane-aligned by the initiator.
REQ-011 SHALL have port req_wmask  in  8  byte-lane write enables; bit i enables byte i.
REQ-012 SHALL have port resp_valid  out  1  response present.
REQ-013 SHALL have port resp_ready  in  1  initiator accepts the response.
REQ-014 SHALL have port resp_rdata  out  64  full aligned word for reads; 0 for writes.
REQ-015 SHALL have port resp_err  out  1  address out of range.
REQ-016 SHALL have port rd_cnt  out  32  count of completed read responses.
REQ-017 SHALL have port wr_cnt  out  32  count of completed write responses.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE, and resp_valid=1 only in RESP.
REQ-019 SHALL accept a request on a rising edge where req_valid && req_ready, capturing wen, addr, wdata and wmask.
REQ-020 On acceptance the FSM SHALL go IDLE->RESP if LATENCY==0; otherwise IDLE->WAIT with cnt=LATENCY-1.
REQ-021 In WAIT the FSM SHALL go to RESP when cnt==0, else decrement cnt.
REQ-022 For a request accepted in cycle T, resp_valid SHALL first be high in cycle T+1+LATENCY.
REQ-023 Word index SHALL be (addr-BASE)>>3; addr[2:0] SHALL be ignored, because lane extraction is the initiator's job.
REQ-024 In range SHALL mean BASE <= addr < BASE + 8*2^DEPTH_LOG2; otherwise resp_err=1, no array update, resp_rdata=0.
REQ-025 An in-range write SHALL update only the bytes whose wmask bit is set, on the edge of entry to RESP; the other bytes SHALL be unchanged.
REQ-026 wmask=0 SHALL be a legal no-op write that still produces a response.
REQ-027 Read data SHALL be sampled on the edge of entry to RESP; reads SHALL observe all previously completed writes.
REQ-028 resp_rdata and resp_err SHALL hold stable while resp_valid && !resp_ready.
REQ-029 On resp_valid && resp_ready the FSM SHALL go to IDLE; req_ready SHALL rise the next cycle, with no same-cycle re-accept.
REQ-030 Maximum throughput SHALL be 1 transaction per LATENCY+2 cycles when resp_ready is held at 1.
REQ-031 rd_cnt / wr_cnt SHALL increment on each response handshake of that type, errored ones included.
REQ-032 rd_cnt / wr_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-033 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-034 rst_n low SHALL immediately force the FSM to IDLE, cnt=0, resp_valid=0, resp_rdata=0, resp_err=0, rd_cnt=0, wr_cnt=0.
REQ-035 req_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-036 Array contents SHALL NOT be reset.
REQ-037 Reset during WAIT SHALL abort the transaction: no response, and no array update for a pending write.

Verification
REQ-038 Bench SHALL cover: write addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF, then read 0x8000_0013 -> rdata 0x1122334455667788, resp_err=0, resp_valid 3 cycles after each accept.
REQ-039 Bench SHALL cover: preload 0x8000_0010 = 0x1122334455667788; write wdata 0x0000_0000_AB00_0000, wmask 0x08; read -> 0x11223344AB667788.
REQ-040 Bench SHALL cover: read 0x8000_0800 and write 0x7FFF_FFF8 -> resp_err=1, rdata=0; a later read of word 0 shows no change.
REQ-041 Bench SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stable and req_ready=0 throughout; rd_cnt increments only on the handshake.
REQ-042 Bench SHALL cover: rst_n pulsed low during WAIT of a write to 0x8000_0020 -> resp_valid=0 and req_ready=1 after release; a read of 0x8000_0020 returns the old value.
REQ-043 Bench SHALL cover: LATENCY=0 build with resp_ready=1 and back-to-back reads -> one accept every 2 cycles.

Source files
------------

// File: rtl/ysyx_22050612_mem_resp.sv
// Latency-configurable 64-bit word memory responder.
// Serves one valid/ready request at a time and counts read/write responses.
module ysyx_22050612_mem_resp #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q;
  logic [31:0] rd_cnt_q, wr_cnt_q;

  logic [63:0] mem [DEPTH];

  logic        accept;
  logic        hs;
  logic        enter_resp;
  logic        e_wen;
  logic [63:0] e_addr;
  logic [63:0] e_wdata;
  logic [7:0]  e_wmask;
  logic [63:0] off;
  logic [63:0] widx;
  logic        in_range;
  logic        mem_we;
  logic [DEPTH_LOG2-1:0] idx;

  assign req_ready  = rst_n && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

  assign accept = req_valid && req_ready;
  assign hs     = resp_valid && resp_ready;

  // With zero latency RESP is entered on the accept edge itself,
  // so the live request fields must be used instead of the copies.
  assign e_wen   = (state_q == IDLE) ? req_wen   : wen_q;
  assign e_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign e_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign e_wmask = (state_q == IDLE) ? req_wmask : wmask_q;

  assign off      = e_addr - BASE;
  assign widx     = off >> 3;
  assign in_range = (e_addr >= BASE) && (widx < 64'(DEPTH));
  assign idx      = widx[DEPTH_LOG2-1:0];
  assign mem_we   = enter_resp && e_wen && in_range;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = (in_range && !e_wen) ? mem[idx] : 64'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      wmask_q  <= 8'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end
      if (enter_resp) err_q <= !in_range;
      if (hs) begin
        if (wen_q) wr_cnt_q <= wr_cnt_q + 32'd1;
        else       rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (e_wmask[i]) mem[idx][8*i +: 8] <= e_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_resp.sv
// Scoreboard bench for ysyx_22050612_mem_resp.
// Covers the LATENCY=2 default build and a LATENCY=0 build.
module tb_ysyx_22050612_mem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_wen = 1'b0;
  logic [63:0] d_req_addr = 64'd0;
  logic [63:0] d_req_wdata = 64'd0;
  logic [7:0]  d_req_wmask = 8'd0;
  logic        d_resp_valid;
  logic        d_resp_ready = 1'b1;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;
  logic [31:0] d_rd_cnt, d_wr_cnt;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_wen = 1'b0;
  logic [63:0] z_req_addr = 64'd0;
  logic [63:0] z_req_wdata = 64'd0;
  logic [7:0]  z_req_wmask = 8'd0;
  logic        z_resp_valid;
  logic        z_resp_ready = 1'b1;
  logic [63:0] z_resp_rdata;
  logic        z_resp_err;
  logic [31:0] z_rd_cnt, z_wr_cnt;

  ysyx_22050612_mem_resp u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_wen(d_req_wen), .req_addr(d_req_addr),
    .req_wdata(d_req_wdata), .req_wmask(d_req_wmask),
    .resp_valid(d_resp_valid), .resp_ready(d_resp_ready),
    .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
    .rd_cnt(d_rd_cnt), .wr_cnt(d_wr_cnt)
  );

  ysyx_22050612_mem_resp #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_wen(z_req_wen), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err),
    .rd_cnt(z_rd_cnt), .wr_cnt(z_wr_cnt)
  );

  typedef struct {
    logic [63:0] rdata;
    bit          err;
    bit          wen;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   exp_rd = 0;
  int   exp_wr = 0;
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response with the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = 0;
      exp_wr = 0;
      seen   = 1'b0;
    end else if (d_resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_resp: got valid want idle (cycle %0d)", cyc);
      end else begin
        if (!seen) begin
          chk("resp_latency", 64'(cyc), 64'(sb[0].acc + 3));
          seen = 1'b1;
        end
        chk("rdata", d_resp_rdata, sb[0].rdata);
        chk("err", 64'(d_resp_err), 64'(sb[0].err));
        chk("req_ready_busy", 64'(d_req_ready), 64'd0);
        if (d_resp_ready) begin
          if (sb[0].wen) exp_wr++;
          else           exp_rd++;
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic xact(input bit w, input logic [63:0] a,
                      input logic [63:0] wd, input logic [7:0] m,
                      input logic [63:0] er, input bit ee,
                      input bit push);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    d_req_valid = 1'b1;
    d_req_wen   = w;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_wmask = m;
    @(negedge clk);
    while (!d_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!d_req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no ready want ready (addr %h)", a);
    end else if (push) begin
      sb.push_back('{er, ee, w, cyc});
    end
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    int last_acc;
    int nacc;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(d_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(d_resp_valid), 64'd0);
    chk("rst_rdata", d_resp_rdata, 64'd0);
    chk("rst_err", 64'(d_resp_err), 64'd0);
    chk("rst_rd_cnt", 64'(d_rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(d_wr_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", 64'(d_req_ready), 64'd1);

    // full write, then unaligned read of the same word
    xact(1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'd0, 0, 1);
    xact(0, 64'h8000_0013, 64'd0, 8'h00, 64'h1122334455667788, 0, 1);
    // single-byte lane update
    xact(1, 64'h8000_0010, 64'h0000_0000_AB00_0000, 8'h08, 64'd0, 0, 1);
    xact(0, 64'h8000_0010, 64'd0, 8'h00, 64'h11223344AB667788, 0, 1);
    // empty mask is a no-op write
    xact(1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 0, 1);
    xact(0, 64'h8000_0017, 64'd0, 8'h00, 64'h11223344AB667788, 0, 1);
    // range boundaries
    xact(1, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 0, 1);
    xact(1, 64'h8000_07F8, 64'hFEDCBA9876543210, 8'hFF, 64'd0, 0, 1);
    xact(0, 64'h8000_0800, 64'd0, 8'h00, 64'd0, 1, 1);
    xact(1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1, 1);
    xact(0, 64'h8000_0000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 0, 1);
    xact(0, 64'h8000_07F8, 64'd0, 8'h00, 64'hFEDCBA9876543210, 0, 1);
    drain();
    chk("rd_cnt_a", 64'(d_rd_cnt), 64'(exp_rd));
    chk("wr_cnt_a", 64'(d_wr_cnt), 64'(exp_wr));

    // back-pressure: response must hold for 5 stalled cycles
    d_resp_ready = 1'b0;
    xact(0, 64'h8000_0010, 64'd0, 8'h00, 64'h11223344AB667788, 0, 1);
    n = 0;
    while (!d_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = exp_rd;
    repeat (5) begin
      chk("stall_valid", 64'(d_resp_valid), 64'd1);
      chk("stall_rd_cnt", 64'(d_rd_cnt), 64'(snap));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    d_resp_ready = 1'b1;
    drain();
    chk("stall_rd_cnt_after", 64'(d_rd_cnt), 64'(snap + 1));

    // reset in the middle of a pending write
    xact(1, 64'h8000_0020, 64'h5555AAAA5555AAAA, 8'hFF, 64'd0, 0, 1);
    drain();
    xact(1, 64'h8000_0020, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'd0, 0, 0);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wrst_req_ready", 64'(d_req_ready), 64'd0);
    chk("wrst_resp_valid", 64'(d_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(d_resp_valid), 64'd0);
      chk("post_rst_ready", 64'(d_req_ready), 64'd1);
    end
    chk("post_rst_wr_cnt", 64'(d_wr_cnt), 64'd0);
    chk("post_rst_err", 64'(d_resp_err), 64'd0);
    xact(0, 64'h8000_0020, 64'd0, 8'h00, 64'h5555AAAA5555AAAA, 0, 1);
    drain();
    chk("rd_cnt_b", 64'(d_rd_cnt), 64'(exp_rd));
    chk("wr_cnt_b", 64'(d_wr_cnt), 64'(exp_wr));

    // zero-latency build: one accept every two cycles
    @(posedge clk);
    #1;
    z_req_valid = 1'b1;
    z_req_wen   = 1'b1;
    z_req_addr  = 64'h8000_0040;
    z_req_wdata = 64'h0F0E0D0C0B0A0908;
    z_req_wmask = 8'hFF;
    @(negedge clk);
    chk("z_ready", 64'(z_req_ready), 64'd1);
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_wr_valid", 64'(z_resp_valid), 64'd1);
    chk("z_wr_err", 64'(z_resp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    z_req_valid = 1'b1;
    z_req_wen   = 1'b0;
    z_req_addr  = 64'h8000_0044;
    last_acc = -1;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (z_resp_valid) begin
        chk("z_resp_cycle", 64'(cyc), 64'(last_acc + 1));
        chk("z_rdata", z_resp_rdata, 64'h0F0E0D0C0B0A0908);
      end
      if (z_req_ready) begin
        if (last_acc >= 0)
          chk("z_accept_gap", 64'(cyc - last_acc), 64'd2);
        last_acc = cyc;
        nacc++;
      end
    end
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_accepts", 64'(nacc), 64'd5);
    chk("z_rd_cnt", 64'(z_rd_cnt), 64'd5);
    chk("z_wr_cnt", 64'(z_wr_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
